// File: rtl/router_controller_mp.sv
// Router controller: memory-read arbiter handshake, local header injection and a
// round-robin TTL-based flit forwarder. Define ROUTER_DROP_CNT_EN to add drop_cnt.
module router_controller_mp #(
   parameter int DATA_WIDTH      = 64,
   parameter int ADDR_WIDTH      = 10,
   parameter int NUM_PORTS       = 4,
   parameter int NUMBER_PACKET   = 19,
   parameter int TTL_INIT        = 2,
   parameter int ROUTER_ID_WIDTH = 2,
   parameter int ROUTER_ID       = 0,
   localparam int TTL_W          = 2,
   localparam int PN_W           = $clog2(NUMBER_PACKET + 1),
   localparam int HDR_W          = TTL_W + PN_W + ROUTER_ID_WIDTH
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            start_req,
   input  logic [ADDR_WIDTH-1:0]           start_src_addr,
   input  logic [ADDR_WIDTH-1:0]           start_dst_addr,
   output logic                            done,
   output logic                            read_req,
   input  logic                            read_gnt,
   output logic [ADDR_WIDTH-1:0]           arb_src_addr,
   input  logic                            encap_ready,
   output logic [ADDR_WIDTH-1:0]           dst_addr_send,
   output logic [HDR_W-1:0]                header_send,
   input  logic [NUM_PORTS-1:0]            in_empty,
   output logic [NUM_PORTS-1:0]            in_rd,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_data,
   input  logic [NUM_PORTS-1:0]            out_full,
   output logic [NUM_PORTS-1:0]            out_we,
   output logic [DATA_WIDTH-1:0]           out_data,
   input  logic                            local_full,
   output logic                            local_we
`ifdef ROUTER_DROP_CNT_EN
   ,
   output logic [15:0]                     drop_cnt
`endif
);

   localparam int PTR_W = $clog2(NUM_PORTS);

   typedef enum logic [1:0] {IDLE, RD, CAP, WR} state_t;

   state_t                 state;
   logic [PTR_W-1:0]       rr_ptr;
   logic [PTR_W-1:0]       sel;
   logic [NUM_PORTS-1:0]   tgt;
   logic                   served;
   logic [PN_W-1:0]        pkt_num;
   logic [DATA_WIDTH-1:0]  cap_flit;
   logic [DATA_WIDTH-1:0]  mod_flit;
   logic [TTL_W-1:0]       cap_ttl;

   function automatic logic [PTR_W-1:0] pick_port(input logic [NUM_PORTS-1:0] emp,
                                                  input logic [PTR_W-1:0]     ptr);
      logic [PTR_W-1:0] r;
      logic [PTR_W-1:0] idx;
      logic             found;
      r     = ptr;
      found = 1'b0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         idx = PTR_W'((int'(ptr) + k) % NUM_PORTS);
         if (!found && !emp[idx]) begin
            r     = idx;
            found = 1'b1;
         end
      end
      return r;
   endfunction

   function automatic logic [NUM_PORTS-1:0] port_bit(input logic [PTR_W-1:0] p);
      return NUM_PORTS'(1) << p;
   endfunction

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(NUM_PORTS - 1)) ? '0 : p + PTR_W'(1);
   endfunction

`ifdef ROUTER_DROP_CNT_EN
   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction
`endif

   // Arbiter: one grant per start_req assertion; served blocks re-requesting until start_req drops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         read_req     <= 1'b0;
         done         <= 1'b0;
         served       <= 1'b0;
         arb_src_addr <= '0;
      end else if (!start_req) begin
         read_req     <= 1'b0;
         done         <= 1'b0;
         served       <= 1'b0;
         arb_src_addr <= '0;
      end else if (read_req && read_gnt) begin
         read_req <= 1'b0;
         done     <= 1'b1;
         served   <= 1'b1;
      end else begin
         done <= 1'b0;
         if (!served) begin
            read_req     <= 1'b1;
            arb_src_addr <= start_src_addr;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pkt_num       <= PN_W'(1);
         header_send   <= '0;
         dst_addr_send <= '0;
      end else if (encap_ready) begin
         header_send   <= {TTL_W'(TTL_INIT), pkt_num, ROUTER_ID_WIDTH'(ROUTER_ID)};
         dst_addr_send <= start_dst_addr;
         pkt_num       <= (pkt_num == PN_W'(NUMBER_PACKET)) ? PN_W'(1) : pkt_num + PN_W'(1);
      end
   end

   assign cap_flit = in_data[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
   assign cap_ttl  = cap_flit[HDR_W-1 -: TTL_W];

   always_comb begin
      mod_flit = cap_flit;
      mod_flit[HDR_W-1 -: TTL_W] = (cap_ttl > TTL_W'(1)) ? cap_ttl - TTL_W'(1) : '0;
   end

   // Forwarder: strobes default low so each read/write is a single-cycle pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         rr_ptr   <= '0;
         sel      <= '0;
         tgt      <= '0;
         in_rd    <= '0;
         out_we   <= '0;
         local_we <= 1'b0;
         out_data <= '0;
`ifdef ROUTER_DROP_CNT_EN
         drop_cnt <= '0;
`endif
      end else begin
         in_rd    <= '0;
         out_we   <= '0;
         local_we <= 1'b0;
         case (state)
            IDLE: begin
               if (!(&in_empty)) begin
                  sel   <= pick_port(in_empty, rr_ptr);
                  in_rd <= port_bit(pick_port(in_empty, rr_ptr));
                  state <= RD;
               end
            end
            RD: state <= CAP;
            CAP: begin
               if (cap_ttl == '0) begin
                  rr_ptr <= next_ptr(sel);
                  state  <= IDLE;
`ifdef ROUTER_DROP_CNT_EN
                  drop_cnt <= sat_inc(drop_cnt);
`endif
               end else begin
                  out_data <= mod_flit;
                  tgt      <= (cap_ttl > TTL_W'(1)) ? ~port_bit(sel) : '0;
                  state    <= WR;
               end
            end
            WR: begin
               // All targets must be free together so the flit is never half-delivered.
               if (!local_full && ((tgt & out_full) == '0)) begin
                  local_we <= 1'b1;
                  out_we   <= tgt;
                  rr_ptr   <= next_ptr(sel);
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
